// File: rtl/fsm_mod_counter.sv
// Modulo-MODULO up/down counter built as an explicit state-register FSM with clear, load and terminal count.
// Optional sticky overflow flag (ports ovf_clr/ovf) when FSM_CNT_OVF_STICKY_EN is defined.
module fsm_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
`ifdef FSM_CNT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULO == 2**WIDTH is representable in comparisons.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] ST_ZERO = '0;
  localparam logic [WIDTH-1:0] ST_LAST = WIDTH'(MODULO - 1);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} >= MOD_EXT) return ST_LAST;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c == ST_LAST) return SATURATE ? c : ST_ZERO;
    return c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] c);
    if (c == ST_ZERO) return SATURATE ? c : ST_LAST;
    return c - WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] count_nxt;
  logic             at_term;
  logic             illegal;
  logic             wrap_nxt;

  always_comb begin
    at_term = up_dn ? (count == ST_LAST) : (count == ST_ZERO);
    illegal = ({1'b0, count} >= MOD_EXT);
    tc      = en & ~clr & ~load & at_term;
    wrap_nxt = !SATURATE && tc;

    count_nxt = count;
    if (clr)          count_nxt = ST_ZERO;
    else if (load)    count_nxt = clamp_load(load_val);
    else if (illegal) count_nxt = ST_ZERO;   // recovery arm, ignores en
    else if (en)      count_nxt = up_dn ? step_up(count) : step_dn(count);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= ST_ZERO;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

`ifdef FSM_CNT_OVF_STICKY_EN
  // tc already implies the step is taken, so it doubles as the overflow event; set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf <= 1'b0;
    else if (tc)      ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fsm_mod_counter.sv
// Directed bench for fsm_mod_counter: vector table for wrap/down/priority, hand sequences for saturate, async reset, ovf.
module tb_fsm_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, clr, load, up_dn, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] count0, count1;
  logic       tc0, tc1, wrap0, wrap1;
`ifdef FSM_CNT_OVF_STICKY_EN
  logic       ovf0, ovf1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn),
`ifdef FSM_CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf0),
`endif
    .count(count0), .tc(tc0), .wrap(wrap0));

  fsm_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn),
`ifdef FSM_CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf1),
`endif
    .count(count1), .tc(tc1), .wrap(wrap1));

  typedef struct {
    bit       clr, load, en, up_dn;
    bit [3:0] lv;
    bit       exp_tc;
    bit [3:0] exp_cnt;
    bit       exp_wrap;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  function automatic vec_t mk(bit c, bit l, bit e, bit u, bit [3:0] lv,
                              bit t, bit [3:0] cnt, bit w);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up_dn = u; v.lv = lv;
    v.exp_tc = t; v.exp_cnt = cnt; v.exp_wrap = w;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit u, input bit [3:0] lv);
    clr = c; load = l; en = e; up_dn = u; load_val = lv;
  endtask

  initial begin
    reset_n = 1'b0; ovf_clr = 1'b0;
    drive(0, 0, 0, 1, 4'd0);

    // Test 1: up count across the wrap.
    for (int k = 0; k < 12; k++) begin
      int c;
      c = k % 10;
      vecs[nvec++] = mk(0, 0, 1, 1, 4'd0, c == 9, 4'((c + 1) % 10), c == 9);
    end
    // Test 2: load 2, then count down through 0.
    vecs[nvec++] = mk(0, 1, 0, 0, 4'd2, 0, 4'd2, 0);
    vecs[nvec++] = mk(0, 0, 1, 0, 4'd0, 0, 4'd1, 0);
    vecs[nvec++] = mk(0, 0, 1, 0, 4'd0, 0, 4'd0, 0);
    vecs[nvec++] = mk(0, 0, 1, 0, 4'd0, 1, 4'd9, 1);
    vecs[nvec++] = mk(0, 0, 1, 0, 4'd0, 0, 4'd8, 0);
    // Test 3: priority, clamping, hold and tc masking.
    vecs[nvec++] = mk(1, 1, 1, 1, 4'd5, 0, 4'd0, 0);
    vecs[nvec++] = mk(0, 1, 0, 1, 4'd13, 0, 4'd9, 0);
    vecs[nvec++] = mk(0, 1, 0, 1, 4'd10, 0, 4'd9, 0);
    vecs[nvec++] = mk(0, 0, 0, 1, 4'd0, 0, 4'd9, 0);
    vecs[nvec++] = mk(0, 1, 1, 1, 4'd3, 0, 4'd3, 0);
    vecs[nvec++] = mk(1, 0, 1, 0, 4'd0, 0, 4'd0, 0);
    vecs[nvec++] = mk(1, 0, 1, 0, 4'd0, 0, 4'd0, 0);
    vecs[nvec++] = mk(0, 1, 1, 1, 4'd9, 0, 4'd9, 0);
    vecs[nvec++] = mk(0, 0, 1, 0, 4'd0, 0, 4'd8, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count0, 0);
    chk("reset_wrap", wrap0, 0);
    chk("reset_tc", tc0, 0);
`ifdef FSM_CNT_OVF_STICKY_EN
    chk("reset_ovf", ovf0, 0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].lv);
      #1;
      chk($sformatf("vec%0d_tc", i), tc0, vecs[i].exp_tc);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), count0, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_wrap", i), wrap0, vecs[i].exp_wrap);
    end

    // Test 4: saturating instance counts up from 7 and holds at 9.
    drive(0, 1, 0, 1, 4'd7);
    @(posedge clk); #1;
    chk("sat_load", count1, 7);
    begin
      bit [3:0] exp_s [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
      bit       exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      drive(0, 0, 1, 1, 4'd0);
      for (int k = 0; k < 5; k++) begin
        #1;
        chk($sformatf("sat_up%0d_tc", k), tc1, exp_t[k]);
        @(posedge clk); #1;
        chk($sformatf("sat_up%0d_count", k), count1, exp_s[k]);
        chk($sformatf("sat_up%0d_wrap", k), wrap1, 0);
      end
    end
    drive(1, 0, 0, 1, 4'd0);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 4'd0);
    #1;
    chk("sat_dn_tc", tc1, 1);
    @(posedge clk); #1;
    chk("sat_dn_count", count1, 0);
    chk("sat_dn_wrap", wrap1, 0);
    chk("wrapinst_dn_count", count0, 9);

    // Test 5: asynchronous reset between edges clears wrap and count.
    drive(0, 1, 0, 1, 4'd9);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 4'd0);
    @(posedge clk); #1;
    chk("pre_rst_wrap", wrap0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_wrap", wrap0, 0);
    @(negedge clk) reset_n = 1'b1;
    drive(1, 0, 0, 1, 4'd0);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 4'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_count", count0, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", count0, 0);
    chk("async_rst_wrap2", wrap0, 0);
    @(posedge clk); #1;
    chk("held_in_rst", count0, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("resume_count", count0, 1);

`ifdef FSM_CNT_OVF_STICKY_EN
    // Test 6: sticky overflow, set beats simultaneous clear.
    drive(0, 0, 0, 1, 4'd0); ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_cleared0", ovf0, 0);
    drive(0, 1, 0, 1, 4'd9);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 4'd0);
    @(posedge clk); #1;
    chk("ovf_set", ovf0, 1);
    drive(1, 0, 0, 1, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_held", ovf0, 1);
    drive(0, 1, 0, 1, 4'd9);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 4'd0); ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("ovf_set_wins", ovf0, 1);
    drive(0, 0, 0, 1, 4'd0);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", ovf0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
